// File: rtl/updown_counter_nbit_pkg.sv
// rtl/updown_counter_nbit_pkg.sv - shared types, defaults and step decode for the up/down counter
package updown_counter_nbit_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DN   = 2'd2
   } step_e;

   localparam int DEFAULT_WIDTH       = 4;
   localparam int DEFAULT_MOD         = 16;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Opposite triggers in the same cycle cancel to no step at all.
   function automatic step_e decode_step(input logic up, input logic dn);
      step_e s;
      s = STEP_NONE;
      if (up && !dn) begin
         s = STEP_UP;
      end else if (dn && !up) begin
         s = STEP_DN;
      end
      return s;
   endfunction

endpackage

// File: rtl/updown_counter_nbit_if.sv
// rtl/updown_counter_nbit_if.sv - control and status bundle between counter and its user
interface updown_counter_nbit_if
   import updown_counter_nbit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             x_up;
   logic             x_dn;
   logic             mode_sat;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             wrap_pulse;
   logic             at_bound;

   modport master (
      output x_up, x_dn, mode_sat, clr, load, load_val,
      input  count, wrap_pulse, at_bound
   );

   modport slave (
      input  x_up, x_dn, mode_sat, clr, load, load_val,
      output count, wrap_pulse, at_bound
   );
endinterface

// File: rtl/edge_sync_detect.sv
// rtl/edge_sync_detect.sv - synchroniser plus registered one-cycle rising-edge pulse
module edge_sync_detect
   import updown_counter_nbit_pkg::*;
#(
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic x,
   output logic trig
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   trig_q;

   // History clears on reset, so a level already high at release counts once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         trig_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], x};
         prev_q <= sync_q[SYNC_STAGES-1];
         trig_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign trig = trig_q;
endmodule

// File: rtl/updown_counter_nbit.sv
// rtl/updown_counter_nbit.sv - modulo up/down counter stepped by synchronised input edges
module updown_counter_nbit
   import updown_counter_nbit_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int MOD         = DEFAULT_MOD,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic                  clk,
   input  logic                  rst,
   updown_counter_nbit_if.slave  bus
);
   localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MOD);
   localparam logic [WIDTH-1:0] TOP_C = WIDTH'(MOD - 1);

   logic             up_trig;
   logic             dn_trig;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   logic [WIDTH:0]   cur_x;
   logic [WIDTH:0]   inc_x;
   logic [WIDTH:0]   load_x;
   mode_e            mode;
   step_e            step;

   edge_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_up_sync (
      .clk  (clk),
      .rst  (rst),
      .x    (bus.x_up),
      .trig (up_trig)
   );

   edge_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_dn_sync (
      .clk  (clk),
      .rst  (rst),
      .x    (bus.x_dn),
      .trig (dn_trig)
   );

   // One extra bit keeps the increment and the load comparison free of overflow when MOD == 2**WIDTH.
   always_comb begin
      cur_x   = {1'b0, count_q};
      inc_x   = cur_x + (WIDTH+1)'(1);
      load_x  = {1'b0, bus.load_val};
      mode    = mode_e'(bus.mode_sat);
      step    = decode_step(up_trig, dn_trig);
      count_d = count_q;
      wrap_d  = 1'b0;

      if (bus.clr) begin
         count_d = '0;
      end else if (bus.load) begin
         count_d = (load_x >= MOD_X) ? TOP_C : bus.load_val;
      end else begin
         case (step)
            STEP_UP: begin
               if (inc_x >= MOD_X) begin
                  if (mode == MODE_WRAP) begin
                     count_d = '0;
                     wrap_d  = 1'b1;
                  end
               end else begin
                  count_d = inc_x[WIDTH-1:0];
               end
            end
            STEP_DN: begin
               if (count_q == '0) begin
                  if (mode == MODE_WRAP) begin
                     count_d = TOP_C;
                     wrap_d  = 1'b1;
                  end
               end else begin
                  count_d = count_q - WIDTH'(1);
               end
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.count      = count_q;
   assign bus.wrap_pulse = wrap_q;
   assign bus.at_bound   = (count_q == '0) || (count_q == TOP_C);
endmodule
